nlp_token_stream: RTL
=====================

Name: nlp_token_stream

Overview:
- Parametrised successor to the byte-level keyword front end of the speech/NLP pipeline.
- Accepts a character stream with a valid/ready handshake and segments it into words on delimiters.
- Hashes each word into a keyword address and queues (address, length, truncated) records in an internal FIFO.
- The LSTM/predict stages drain the FIFO with their own valid/ready handshake. This decouples input rate from lookup rate and replaces the fixed delay-stage alignment.

Parameters:
- DW, 8: character width in bits.
- AW, 8: keyword address width. Must satisfy AW >= DW and AW >= 4.
- MAX_CHARS, 16: characters per word that contribute to the hash. Also the length saturation value.
- DEPTH, 8: token FIFO entries. Power of 2, >= 2.
- LW, 5: length field width. Must satisfy 2^LW > MAX_CHARS.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- datain, input, DW: character byte.
- din_valid, input, 1: datain valid.
- din_ready, output, 1: block accepts datain this cycle.
- tok_addr, output, AW: head-of-FIFO keyword address.
- tok_len, output, LW: head-of-FIFO word length, saturated.
- tok_trunc, output, 1: head word exceeded MAX_CHARS.
- tok_valid, output, 1: FIFO non-empty.
- tok_ready, input, 1: consumer pops the head when tok_valid is also high.
- fifo_count, output, clog2(DEPTH)+1: occupancy.
- overflow, output, 1: sticky. Set on a push attempt while full; cleared only by rst.

Behaviour:
- Reset: all outputs 0, except din_ready = 1. FSM goes to IDLE; hash, length and FIFO pointers are cleared.
- Accept condition: din_valid & din_ready at a rising edge.
- Delimiter: datain equal to 0x20, 0x0A or 0x00, zero-extended to DW. Any other value is a word character.
- Hash update per accepted word character: h <= rotl(h, 3) ^ zero_ext(datain). Only the first MAX_CHARS characters update h. h starts at 0 for each word.
- Length update: len increments per accepted character, saturating at MAX_CHARS. trunc sets when a character arrives with len already == MAX_CHARS.
- FSM states:
  - IDLE: no word in progress; din_ready = 1. A delimiter is consumed and dropped, so empty words are never queued. A word character loads h = zero_ext(datain), len = 1, and moves to COLLECT.
  - COLLECT: din_ready = 1. A word character updates h/len/trunc. A delimiter moves to PUSH.
  - PUSH: din_ready = 0. If the FIFO is not full, or a pop occurs in the same cycle, write {h, len, trunc}, clear the word state and go to IDLE. Otherwise hold in PUSH (back-pressure); no data is lost.
- overflow sets in a PUSH cycle where the FIFO is full and no pop occurs. Because PUSH waits, the flag indicates a stall event, not data loss.
- Latency: delimiter accepted at edge N → entry written at edge N+1 (FIFO not full) → tok_valid high after edge N+1. Next word character can be accepted at edge N+2.
- FIFO: first-word-fall-through. tok_* reflect the head whenever tok_valid = 1. Pointers wrap modulo DEPTH.
- Simultaneous push and pop: fifo_count unchanged. Allowed when full; the pop frees the slot in the same cycle.
- Pop while empty: ignored; count does not underflow.
- tok_* outputs are stable while tok_valid = 1 and tok_ready = 0.
- rst asserted mid-word or mid-PUSH: immediate return to the reset state. The partial word and all queued tokens are discarded.

Test Plan:
- Reset: assert rst → din_ready = 1, tok_valid = 0, fifo_count = 0, overflow = 0.
- Basic word, AW=8, tok_ready = 1: send "hi " (0x68, 0x69, 0x20) → one token, tok_addr = 0x2A, tok_len = 2, tok_trunc = 0. tok_valid rises 1 cycle after the delimiter is accepted.
- Empty words: send 0x20, 0x20, 0x61, 0x0A, 0x00 → exactly one token, addr 0x61, len 1.
- Truncation: MAX_CHARS = 16, send 20 × 0x61 then 0x20 → len = 16, tok_trunc = 1. tok_addr equals the hash of the first 16 characters only.
- Back-pressure, DEPTH = 8, tok_ready = 0: send 9 one-character words → fifo_count = 8. din_ready stays 0 in PUSH for the 9th word and overflow = 1. Raise tok_ready for 1 cycle → 9th token is written the same cycle, count stays 8. Draining returns tokens in order.
- Reset mid-operation: 3 tokens queued plus a partial word, pulse rst → count = 0, tok_valid = 0. The next word is hashed from h = 0.

Source files
------------

// File: rtl/nlp_token_stream_if.sv
// Token-stream bus: character input handshake plus token FIFO output handshake
// and status. The master drives characters and pops tokens; the slave is the
// segmenting/hashing block.
interface nlp_token_stream_if #(
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = 8,
    parameter int unsigned LW    = 5,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [DW-1:0] datain;
    logic          din_valid;
    logic          din_ready;
    logic [AW-1:0] tok_addr;
    logic [LW-1:0] tok_len;
    logic          tok_trunc;
    logic          tok_valid;
    logic          tok_ready;
    logic [CW-1:0] fifo_count;
    logic          overflow;

    modport master (
        output datain,
        output din_valid,
        output tok_ready,
        input  din_ready,
        input  tok_addr,
        input  tok_len,
        input  tok_trunc,
        input  tok_valid,
        input  fifo_count,
        input  overflow
    );

    modport slave (
        input  datain,
        input  din_valid,
        input  tok_ready,
        output din_ready,
        output tok_addr,
        output tok_len,
        output tok_trunc,
        output tok_valid,
        output fifo_count,
        output overflow
    );
endinterface

// File: rtl/nlp_token_stream.sv
// Word segmenter and keyword hasher. Characters are folded into a rotate/xor
// hash until a delimiter, then the (address, length, truncated) record is
// queued in a first-word-fall-through FIFO that the lookup stages drain.
module nlp_token_stream #(
    parameter int unsigned DW        = 8,
    parameter int unsigned AW        = 8,
    parameter int unsigned MAX_CHARS = 16,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned LW        = 5
) (
    input logic             clk,
    input logic             rst,
    nlp_token_stream_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned XW = DW + 8;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StPush
    } state_e;

    state_e        r_state;
    state_e        w_state_next;
    logic [AW-1:0] r_hash;
    logic [AW-1:0] w_hash_next;
    logic [LW-1:0] r_len;
    logic [LW-1:0] w_len_next;
    logic          r_trunc;
    logic          w_trunc_next;

    logic [AW-1:0] r_mem_addr  [DEPTH];
    logic [LW-1:0] r_mem_len   [DEPTH];
    logic          r_mem_trunc [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic [XW-1:0] w_din_ext;
    logic [AW-1:0] w_char;
    logic [AW-1:0] w_hash_rot;
    logic          w_is_delim;
    logic          w_din_ready;
    logic          w_accept;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic          w_stall;

    // Widen before comparing so delimiter codes stay exact for any DW.
    assign w_din_ext  = XW'(bus.datain);
    assign w_is_delim = (w_din_ext == XW'(8'h20)) || (w_din_ext == XW'(8'h0A)) ||
                        (w_din_ext == '0);
    assign w_char     = AW'(bus.datain);
    assign w_hash_rot = {r_hash[AW-4:0], r_hash[AW-1:AW-3]};

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_pop       = bus.tok_ready && !w_empty;
    assign w_din_ready = (r_state != StPush);
    assign w_accept    = bus.din_valid && w_din_ready;
    // A pop in the same cycle frees the slot, so a full FIFO does not stall then.
    assign w_stall     = (r_state == StPush) && w_full && !w_pop;

    // Word FSM: next state, word hash/length/truncation and the push strobe.
    always_comb begin
        w_state_next = r_state;
        w_hash_next  = r_hash;
        w_len_next   = r_len;
        w_trunc_next = r_trunc;
        w_push       = 1'b0;
        unique case (r_state)
            StIdle: begin
                // Delimiters here are dropped so empty words never reach the FIFO.
                if (w_accept && !w_is_delim) begin
                    w_hash_next  = w_char;
                    w_len_next   = LW'(1);
                    w_trunc_next = 1'b0;
                    w_state_next = StCollect;
                end
            end
            StCollect: begin
                if (w_accept) begin
                    if (w_is_delim) begin
                        w_state_next = StPush;
                    end else if (r_len == LW'(MAX_CHARS)) begin
                        // Hash and length freeze once the word is over-long.
                        w_trunc_next = 1'b1;
                    end else begin
                        w_hash_next = w_hash_rot ^ w_char;
                        w_len_next  = r_len + LW'(1);
                    end
                end
            end
            StPush: begin
                if (!w_stall) begin
                    w_push       = 1'b1;
                    w_hash_next  = '0;
                    w_len_next   = '0;
                    w_trunc_next = 1'b0;
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // FSM and word-state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_hash  <= '0;
            r_len   <= '0;
            r_trunc <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_hash  <= w_hash_next;
            r_len   <= w_len_next;
            r_trunc <= w_trunc_next;
        end
    end

    // FIFO storage; contents are don't-care until the count marks them valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr]  <= r_hash;
            r_mem_len[r_wr_ptr]   <= r_len;
            r_mem_trunc[r_wr_ptr] <= r_trunc;
        end
    end

    // FIFO pointers, occupancy and the sticky stall flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_stall) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Head-of-FIFO outputs, forced to zero while empty so reset reads all-zero.
    always_comb begin
        bus.din_ready  = w_din_ready;
        bus.tok_valid  = !w_empty;
        bus.tok_addr   = '0;
        bus.tok_len    = '0;
        bus.tok_trunc  = 1'b0;
        bus.fifo_count = r_count;
        bus.overflow   = r_overflow;
        if (!w_empty) begin
            bus.tok_addr  = r_mem_addr[r_rd_ptr];
            bus.tok_len   = r_mem_len[r_rd_ptr];
            bus.tok_trunc = r_mem_trunc[r_rd_ptr];
        end
    end
endmodule
